// File: rtl/demux1_16_pipe.sv
// demux1_16_pipe: four-stage registered 1:2 split tree routing one word per cycle to 16 sticky channels
module demux1_16_pipe #(
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [3:0]             select,
  input  logic [15:0]            ack,
  input  logic                   clr_ovr,
  output logic [16*DATA_W-1:0]   out_data,
  output logic [15:0]            out_valid,
  output logic [15:0]            pending,
  output logic [15:0]            overrun,
  output logic                   busy
);
  // Stage n keeps a one-hot branch valid of width 2^n; only one word is ever in a stage, so data is shared
  logic [1:0]            v1_q, v1_d;
  logic [3:0]            v2_q, v2_d;
  logic [7:0]            v3_q, v3_d;
  logic [15:0]           v4_q, v4_d;
  logic [DATA_W-1:0]     d1_q, d1_d, d2_q, d2_d, d3_q, d3_d, d4_q, d4_d;
  logic [2:0]            s1_q, s1_d;
  logic [1:0]            s2_q, s2_d;
  logic                  s3_q, s3_d;
  logic [16*DATA_W-1:0]  out_data_q, out_data_d;
  logic [15:0]           out_valid_q, out_valid_d;
  logic [15:0]           pending_q, pending_d;
  logic [15:0]           overrun_q, overrun_d;

  always_comb begin
    v1_d = {in_valid & select[3], in_valid & ~select[3]};
    d1_d = in_data;
    s1_d = select[2:0];
    v2_d = '0;
    for (int b = 0; b < 2; b++) v2_d[2*b +: 2] = {v1_q[b] & s1_q[2], v1_q[b] & ~s1_q[2]};
    d2_d = d1_q;
    s2_d = s1_q[1:0];
    v3_d = '0;
    for (int b = 0; b < 4; b++) v3_d[2*b +: 2] = {v2_q[b] & s2_q[1], v2_q[b] & ~s2_q[1]};
    d3_d = d2_q;
    s3_d = s2_q[0];
    v4_d = '0;
    for (int b = 0; b < 8; b++) v4_d[2*b +: 2] = {v3_q[b] & s3_q, v3_q[b] & ~s3_q};
    d4_d = d3_q;
    out_valid_d = v4_q;
    out_data_d = out_data_q;
    for (int k = 0; k < 16; k++)
      out_data_d[k*DATA_W +: DATA_W] = v4_q[k] ? d4_q : out_data_q[k*DATA_W +: DATA_W];
    // A delivery beats a same-edge ack: the ack consumes the old word, the new one stays pending
    pending_d = v4_q | (pending_q & ~ack);
    overrun_d = (v4_q & pending_q & ~ack) | (overrun_q & {16{~clr_ovr}});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q <= '0;
      v2_q <= '0;
      v3_q <= '0;
      v4_q <= '0;
      d1_q <= '0;
      d2_q <= '0;
      d3_q <= '0;
      d4_q <= '0;
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= 1'b0;
      out_data_q <= '0;
      out_valid_q <= '0;
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      v4_q <= v4_d;
      d1_q <= d1_d;
      d2_q <= d2_d;
      d3_q <= d3_d;
      d4_q <= d4_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
      out_data_q <= out_data_d;
      out_valid_q <= out_valid_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_data = out_data_q;
  assign out_valid = out_valid_q;
  assign pending = pending_q;
  assign overrun = overrun_q;
  assign busy = |{v1_q, v2_q, v3_q, v4_q};
endmodule
